// File: rtl/trdb_pkg.sv
// Shared packet widths and arbiter state encoding for the trace debugger packet path.
package trdb_pkg;

  localparam int unsigned PACKET_LEN        = 64;
  localparam int unsigned PACKET_HEADER_LEN = 7;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/trdb_rr_select.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping modulo N.
module trdb_rr_select #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  int unsigned pos;
  logic [W-1:0] pos_w;

  // The pointer is always below N, so a single subtraction is enough to wrap
  // even when N is not a power of two.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    pos   = 0;
    pos_w = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = 32'(ptr_i) + k;
      if (pos >= N) pos = pos - N;
      pos_w = W'(pos);
      if (!any_o && (pos < N) && req_i[pos_w]) begin
        any_o = 1'b1;
        idx_o = pos_w;
      end
    end
  end

endmodule

// File: rtl/trdb_packet_arbiter.sv
// Round-robin packet arbiter in front of trdb_stream_align; one-cycle arbitration, offer held until grant_i.
// Whole packets are granted atomically; at most one packet every two cycles.
module trdb_packet_arbiter
  import trdb_pkg::*;
#(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NUM_SRC*PACKET_LEN-1:0]        src_bits_i,
  input  logic [NUM_SRC*PACKET_HEADER_LEN-1:0] src_len_i,
  input  logic [NUM_SRC-1:0]                   src_valid_i,
  output logic [NUM_SRC-1:0]                   src_grant_o,
  input  logic [NUM_SRC-1:0]                   src_en_i,
  output logic [PACKET_LEN-1:0]                packet_bits_o,
  output logic [PACKET_HEADER_LEN-1:0]         packet_len_o,
  output logic                                 valid_o,
  input  logic                                 grant_i,
  output logic [NUM_SRC*CNT_W-1:0]             src_cnt_o,
  output logic                                 proto_err_o
);

  localparam int unsigned PTR_W = $clog2(NUM_SRC);

  arb_state_e         state_q, state_d;
  logic [PTR_W-1:0]   sel_q, sel_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   sel_inc;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_any;
  logic               proto_err_q, err_d;
  logic [NUM_SRC-1:0] cand;
  logic [NUM_SRC-1:0] cnt_inc;
  logic [CNT_W-1:0]   cnt_q [NUM_SRC];
  logic               busy;
  logic               sel_valid;
  logic               fire;

  assign cand      = src_valid_i & src_en_i;
  assign busy      = (state_q == ARB_BUSY);
  assign sel_valid = src_valid_i[sel_q];
  assign sel_inc   = (sel_q == PTR_W'(NUM_SRC - 1)) ? '0 : sel_q + 1'b1;

  trdb_rr_select #(
    .N (NUM_SRC),
    .W (PTR_W)
  ) u_rr_select (
    .req_i (cand),
    .ptr_i (rr_ptr_q),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Outputs are forced low while reset is held so nothing leaks out of a BUSY
  // state that is about to be cleared.
  always_comb begin
    packet_bits_o = '0;
    packet_len_o  = '0;
    valid_o       = 1'b0;
    if (busy && !rst_i) begin
      packet_bits_o = src_bits_i[sel_q*PACKET_LEN +: PACKET_LEN];
      packet_len_o  = src_len_i[sel_q*PACKET_HEADER_LEN +: PACKET_HEADER_LEN];
      valid_o       = sel_valid;
    end
  end

  assign fire = valid_o & grant_i;

  always_comb begin
    src_grant_o = '0;
    if (fire) src_grant_o[sel_q] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    err_d    = proto_err_q;
    cnt_inc  = '0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          sel_d   = pick_idx;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        // Enables are deliberately ignored here: a started packet always completes.
        if (!sel_valid) begin
          state_d = ARB_IDLE;
          err_d   = 1'b1;
        end else if (grant_i) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = sel_inc;
          cnt_inc  = NUM_SRC'(1) << sel_q;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ARB_IDLE;
      sel_q       <= '0;
      rr_ptr_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      rr_ptr_q    <= rr_ptr_d;
      proto_err_q <= err_d;
    end
  end

  assign proto_err_o = proto_err_q;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_cnt
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt_q[i] <= '0;
      end else if (cnt_inc[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
        cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
    assign src_cnt_o[i*CNT_W +: CNT_W] = cnt_q[i];
  end

endmodule

// File: tb/tb_trdb_packet_arbiter.sv
// Bench for trdb_packet_arbiter: directed scenarios with literal expectations plus a randomized run
// compared every cycle against a queue/array-level model of the arbitration rules.
module tb_trdb_packet_arbiter;
  import trdb_pkg::*;

  localparam int N  = 3;
  localparam int CW = 2;
  localparam int PL = PACKET_LEN;
  localparam int HL = PACKET_HEADER_LEN;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*PL-1:0] src_bits;
  logic [N*HL-1:0] src_len;
  logic [N-1:0]    src_valid;
  logic [N-1:0]    src_grant;
  logic [N-1:0]    src_en;
  logic [PL-1:0]   packet_bits;
  logic [HL-1:0]   packet_len;
  logic            valid_o;
  logic            grant;
  logic [N*CW-1:0] src_cnt;
  logic            proto_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trdb_packet_arbiter #(.NUM_SRC(N), .CNT_W(CW)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .src_bits_i    (src_bits),
    .src_len_i     (src_len),
    .src_valid_i   (src_valid),
    .src_grant_o   (src_grant),
    .src_en_i      (src_en),
    .packet_bits_o (packet_bits),
    .packet_len_o  (packet_len),
    .valid_o       (valid_o),
    .grant_i       (grant),
    .src_cnt_o     (src_cnt),
    .proto_err_o   (proto_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: which source owns the output (-1 = none), next source in turn,
  // per-source granted counts and the sticky protocol-error flag.
  bit m_init = 0;
  int m_owner = -1;
  int m_ptr = 0;
  int m_cnt [N];
  bit m_err = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_init  = 1;
      m_owner = -1;
      m_ptr   = 0;
      m_err   = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else if (m_init) begin
      if (m_owner < 0) begin
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (m_ptr + k) % N;
          if (m_owner < 0 && src_valid[idx] && src_en[idx]) m_owner = idx;
        end
      end else if (!src_valid[m_owner]) begin
        m_err   = 1;
        m_owner = -1;
      end else if (grant) begin
        if (m_cnt[m_owner] < (1 << CW) - 1) m_cnt[m_owner] = m_cnt[m_owner] + 1;
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      logic [PL-1:0]   e_bits;
      logic [HL-1:0]   e_len;
      logic            e_valid;
      logic [N-1:0]    e_grant;
      logic [N*CW-1:0] e_cnt;
      e_bits  = '0;
      e_len   = '0;
      e_valid = 1'b0;
      e_grant = '0;
      if (!rst && m_owner >= 0) begin
        e_bits  = src_bits[m_owner*PL +: PL];
        e_len   = src_len[m_owner*HL +: HL];
        e_valid = src_valid[m_owner];
        if (e_valid && grant) e_grant[m_owner] = 1'b1;
      end
      for (int i = 0; i < N; i++) e_cnt[i*CW +: CW] = CW'(m_cnt[i]);
      chk("model valid_o", 64'(valid_o), 64'(e_valid));
      chk("model packet_bits", 64'(packet_bits), 64'(e_bits));
      chk("model packet_len", 64'(packet_len), 64'(e_len));
      chk("model src_grant", 64'(src_grant), 64'(e_grant));
      chk("model src_cnt", 64'(src_cnt), 64'(e_cnt));
      chk("model proto_err", 64'(proto_err), 64'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; src_valid = '0; src_en = '0; grant = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  int order [4];
  int n_ord;

  initial begin
    rst = 1'b1; src_bits = '0; src_len = '0; src_valid = '0; src_en = '0; grant = 1'b0;
    for (int i = 0; i < N; i++) src_bits[i*PL +: PL] = {32'hA5A5_0000 + 32'(i), 32'h1234_5678};
    tick(); tick();
    @(negedge clk);
    chk("reset valid_o", 64'(valid_o), 64'd0);
    chk("reset src_grant", 64'(src_grant), 64'd0);
    chk("reset src_cnt", 64'(src_cnt), 64'd0);
    chk("reset proto_err", 64'(proto_err), 64'd0);
    tick();
    rst = 1'b0;

    // single source, len 10, grant in cycle 3
    src_valid = 3'b001; src_en = 3'b111; src_len[0 +: HL] = HL'(10);
    @(negedge clk); chk("c0 valid_o idle", 64'(valid_o), 64'd0);
    tick(); @(negedge clk);
    chk("c1 valid_o", 64'(valid_o), 64'd1);
    chk("c1 packet_len", 64'(packet_len), 64'd10);
    tick(); tick(); grant = 1'b1;
    @(negedge clk); chk("c3 src_grant", 64'(src_grant), 64'b001);
    tick(); grant = 1'b0; src_valid = '0;
    @(negedge clk);
    chk("c4 valid_o", 64'(valid_o), 64'd0);
    chk("c4 cnt0", 64'(src_cnt[0 +: CW]), 64'd1);

    // two sources alternate
    do_reset();
    src_valid = 3'b011; src_en = 3'b111; grant = 1'b1; n_ord = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (src_grant != '0 && n_ord < 4) begin
        order[n_ord] = (src_grant == 3'b001) ? 0 : (src_grant == 3'b010) ? 1 : 9;
        n_ord++;
      end
      tick();
    end
    grant = 1'b0; src_valid = '0;
    chk("rr grant count", 64'(n_ord), 64'd4);
    chk("rr order0", 64'(order[0]), 64'd0);
    chk("rr order1", 64'(order[1]), 64'd1);
    chk("rr order2", 64'(order[2]), 64'd0);
    chk("rr order3", 64'(order[3]), 64'd1);
    @(negedge clk);
    chk("rr cnt0", 64'(src_cnt[0 +: CW]), 64'd2);
    chk("rr cnt1", 64'(src_cnt[CW +: CW]), 64'd2);

    // enable dropped mid-packet
    do_reset();
    src_valid = 3'b010; src_en = 3'b010;
    tick(); src_en = 3'b000;
    tick(); grant = 1'b1;
    @(negedge clk); chk("en drop grant", 64'(src_grant), 64'b010);
    tick(); grant = 1'b0; src_valid = '0;
    @(negedge clk); chk("en drop cnt1", 64'(src_cnt[CW +: CW]), 64'd1);

    // valid dropped before grant
    do_reset();
    src_valid = 3'b001; src_en = 3'b001;
    tick(); src_valid = 3'b000;
    @(negedge clk); chk("drop no grant", 64'(src_grant), 64'd0);
    tick(); @(negedge clk);
    chk("drop proto_err", 64'(proto_err), 64'd1);
    chk("drop cnt0", 64'(src_cnt[0 +: CW]), 64'd0);

    // saturation with CNT_W = 2
    do_reset();
    src_valid = 3'b001; src_en = 3'b001; grant = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    grant = 1'b0; src_valid = '0;
    @(negedge clk); chk("sat cnt0", 64'(src_cnt[0 +: CW]), 64'd3);

    // reset wins over grant in BUSY
    do_reset();
    src_valid = 3'b001; src_en = 3'b001; grant = 1'b1;
    tick(); tick(); tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rst busy grant", 64'(src_grant), 64'd0);
    chk("rst busy valid", 64'(valid_o), 64'd0);
    tick(); rst = 1'b0; grant = 1'b0; src_valid = '0;
    @(negedge clk);
    chk("post rst valid", 64'(valid_o), 64'd0);
    chk("post rst cnt", 64'(src_cnt), 64'd0);

    // randomized run, checked by the model process
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst       = ($urandom_range(0, 99) == 0);
      src_valid = N'($urandom);
      if (m_owner >= 0 && $urandom_range(0, 9) != 0) src_valid[m_owner] = 1'b1;
      src_en    = N'($urandom);
      grant     = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < N; i++) begin
        src_bits[i*PL +: PL] = {$urandom, $urandom};
        src_len[i*HL +: HL]  = HL'($urandom);
      end
    end
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
